// File: rtl/bimodal_btb_predictor_pkg.sv
// Shared types and constants for the bimodal BTB branch predictor.
package bp_pkg;

  localparam int PC_W = 16;

  // 2-bit bimodal counter; MSB is the taken/not-taken prediction.
  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t CTR_SNT = 2'b00;
  localparam bp_ctr_t CTR_WNT = 2'b01;
  localparam bp_ctr_t CTR_WT  = 2'b10;
  localparam bp_ctr_t CTR_ST  = 2'b11;

  // Tag is held at full PC width (upper bits zero) so the entry layout does
  // not depend on the table size chosen by the instantiating module.
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] tag;
    logic [PC_W-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/bimodal_btb_predictor_if.sv
// Fetch/rf_read/execute signal bundle between the PC controller and the predictor.
interface bimodal_btb_predictor_if;
  import bp_pkg::*;

  logic            valid_rf_read;
  logic            valid_execute;
  logic [PC_W-1:0] current_pc;
  logic            is_pc_jump;
  logic            jump;
  logic [PC_W-1:0] target_pc;
  logic            prediction;
  logic [PC_W-1:0] prediction_pc;

  // Pipeline / PC-controller side.
  modport master (
    output valid_rf_read, valid_execute, current_pc, is_pc_jump, jump, target_pc,
    input  prediction, prediction_pc
  );

  // Predictor side.
  modport slave (
    input  valid_rf_read, valid_execute, current_pc, is_pc_jump, jump, target_pc,
    output prediction, prediction_pc
  );

endinterface

// File: rtl/bimodal_btb_predictor_sat_ctr.sv
// Saturating 2-bit counter step: count up on taken, down on not-taken.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  bp_ctr_t ctr_i,
  input  logic    taken_i,
  output bp_ctr_t ctr_o
);

  // Step the counter, holding at CTR_ST / CTR_SNT.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/bimodal_btb_predictor.sv
// Direct-mapped BTB with 2-bit bimodal counters. Lookup is combinational on
// the fetch PC; the fetch PC is tracked through rf_read and execute, and the
// table is trained on resolved jumps in execute. No lookup/train bypass.
module bimodal_btb_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = $clog2(ENTRIES)
) (
  input logic                     clk,
  input logic                     reset,
  bimodal_btb_predictor_if.slave  bp
);

  btb_entry_t      tbl_q [ENTRIES];
  bp_ctr_t         ctr_q [ENTRIES];

  logic [PC_W-1:0] pc_rf_q;
  logic [PC_W-1:0] pc_ex_q;
  logic            jmp_ex_q;

  logic [INDEX_W-1:0] lk_idx;
  logic [PC_W-1:0]    lk_tag;
  logic               lk_hit;

  logic [INDEX_W-1:0] tr_idx;
  logic [PC_W-1:0]    tr_tag;
  logic               tr_hit;
  logic               tr_en;
  bp_ctr_t            tr_ctr_d;

  // Fetch-stage lookup: predict taken only on a tag hit with a taken-biased counter.
  always_comb begin
    lk_idx           = bp.current_pc[INDEX_W:1];
    lk_tag           = bp.current_pc >> (INDEX_W + 1);
    lk_hit           = tbl_q[lk_idx].valid && (tbl_q[lk_idx].tag == lk_tag);
    bp.prediction    = 1'b0;
    bp.prediction_pc = bp.current_pc + 16'd2;
    if (lk_hit && ctr_q[lk_idx][1]) begin
      bp.prediction    = 1'b1;
      bp.prediction_pc = tbl_q[lk_idx].target;
    end
  end

  // Execute-stage training address decode, using the PC tracked into execute.
  always_comb begin
    tr_idx = pc_ex_q[INDEX_W:1];
    tr_tag = pc_ex_q >> (INDEX_W + 1);
    tr_hit = tbl_q[tr_idx].valid && (tbl_q[tr_idx].tag == tr_tag);
    tr_en  = bp.valid_execute && jmp_ex_q;
  end

  bp_sat_ctr u_sat_ctr (
    .ctr_i   (ctr_q[tr_idx]),
    .taken_i (bp.jump),
    .ctr_o   (tr_ctr_d)
  );

  // Track the fetched PC through rf_read into execute; the jump flag only
  // advances with a valid rf_read instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_rf_q  <= '0;
      pc_ex_q  <= '0;
      jmp_ex_q <= 1'b0;
    end else begin
      pc_rf_q <= bp.current_pc;
      if (bp.valid_rf_read) begin
        pc_ex_q  <= pc_rf_q;
        jmp_ex_q <= bp.is_pc_jump;
      end else begin
        jmp_ex_q <= 1'b0;
      end
    end
  end

  // Table update: counter/target on hit, allocate on taken miss; reset wins over training.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (tr_en) begin
      if (tr_hit) begin
        ctr_q[tr_idx] <= tr_ctr_d;
        if (bp.jump) tbl_q[tr_idx].target <= bp.target_pc;
      end else if (bp.jump) begin
        tbl_q[tr_idx].valid  <= 1'b1;
        tbl_q[tr_idx].tag    <= tr_tag;
        tbl_q[tr_idx].target <= bp.target_pc;
        ctr_q[tr_idx]        <= CTR_WT;
      end
    end
  end

endmodule
